// File: rtl/ifu_pkg.sv
// ifu_pkg: shared FSM state type and instruction-format constants for the fetch unit
package ifu_pkg;
  typedef enum logic [1:0] {S_IDLE, S_FETCH, S_WAIT, S_HOLD} ifu_state_e;
  localparam int INSTR_BYTES = 4;
  localparam int OPCODE_HI = 31;
  localparam int OPCODE_LO = 21;
endpackage

// File: rtl/ifu_if.sv
// ifu_if: instruction-memory request/response bus and decode handshake of the fetch unit
interface ifu_if #(parameter int PC_W = 64);
  logic            imem_req;
  logic [PC_W-1:0] imem_addr;
  logic            imem_valid;
  logic [31:0]     imem_rdata;
  logic            instr_valid;
  logic            instr_ready;
  logic [31:0]     instr;
  logic [10:0]     opcode;
  logic [PC_W-1:0] instr_pc;
  modport master (
    output imem_req, imem_addr, instr_valid, instr, opcode, instr_pc,
    input  imem_valid, imem_rdata, instr_ready
  );
  modport slave (
    input  imem_req, imem_addr, instr_valid, instr, opcode, instr_pc,
    output imem_valid, imem_rdata, instr_ready
  );
endinterface

// File: rtl/ifu_branch_target_adder.sv
// branch_target_adder: target = br_pc + word offset, wrapping modulo 2^PC_W
module branch_target_adder #(parameter int PC_W = 64) (
  input  logic [PC_W-1:0] br_pc,
  input  logic [PC_W-1:0] br_offset,
  output logic [PC_W-1:0] target
);
  assign target = br_pc + (br_offset << 2);
endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: LEGv8 fetch front end, one outstanding fetch, one-entry buffer; IFU_PERF_CNT_EN adds perf counters
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int              PC_W     = 64,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic            CLK,
  input  logic            Reset,
  ifu_if.master           bus,
  input  logic            branch,
  input  logic            uncond_branch,
  input  logic            zero,
  input  logic [PC_W-1:0] br_pc,
  input  logic [PC_W-1:0] br_offset
`ifdef IFU_PERF_CNT_EN
  ,
  output logic [31:0]     perf_fetched,
  output logic [31:0]     perf_squashed
`endif
);
  ifu_state_e state, state_n;
  logic [PC_W-1:0] fetch_pc, fetch_pc_n, target, instr_pc_q;
  logic [31:0] instr_q;
  logic squash, squash_n, br_taken, hs, wait_drop, latch;
  assign br_taken = uncond_branch | (branch & zero);
  branch_target_adder #(.PC_W(PC_W)) u_bta (
    .br_pc     (br_pc),
    .br_offset (br_offset),
    .target    (target)
  );
  assign bus.imem_req    = state == S_FETCH;
  assign bus.imem_addr   = fetch_pc;
  assign bus.instr_valid = (state == S_HOLD) & ~br_taken;
  assign bus.instr       = instr_q;
  assign bus.instr_pc    = instr_pc_q;
  assign bus.opcode      = instr_q[OPCODE_HI:OPCODE_LO];
  assign hs        = bus.instr_valid & bus.instr_ready;
  // a response arriving alongside a redirect, or after one, belongs to the wrong path
  assign wait_drop = (state == S_WAIT) & bus.imem_valid & (squash | br_taken);
  assign latch     = (state == S_WAIT) & bus.imem_valid & ~wait_drop;
  always_comb begin
    state_n    = state;
    squash_n   = squash;
    fetch_pc_n = br_taken ? target : hs ? fetch_pc + PC_W'(INSTR_BYTES) : fetch_pc;
    case (state)
      S_IDLE:  state_n = S_FETCH;
      S_FETCH: begin
        state_n  = S_WAIT;
        squash_n = br_taken;
      end
      S_WAIT: begin
        state_n  = wait_drop ? S_FETCH : latch ? S_HOLD : S_WAIT;
        squash_n = bus.imem_valid ? 1'b0 : squash | br_taken;
      end
      S_HOLD:  state_n = (br_taken | bus.instr_ready) ? S_FETCH : S_HOLD;
      default: state_n = S_IDLE;
    endcase
  end
  always_ff @(posedge CLK) begin
    if (Reset) begin
      state      <= S_IDLE;
      fetch_pc   <= RESET_PC;
      squash     <= 1'b0;
      instr_q    <= '0;
      instr_pc_q <= '0;
    end else begin
      state    <= state_n;
      fetch_pc <= fetch_pc_n;
      squash   <= squash_n;
      if (latch) begin
        instr_q    <= bus.imem_rdata;
        instr_pc_q <= fetch_pc;
      end
    end
  end
`ifdef IFU_PERF_CNT_EN
  always_ff @(posedge CLK) begin
    if (Reset) begin
      perf_fetched  <= '0;
      perf_squashed <= '0;
    end else begin
      perf_fetched  <= perf_fetched + 32'(hs);
      perf_squashed <= perf_squashed + 32'(wait_drop | ((state == S_HOLD) & br_taken));
    end
  end
`endif
endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: scoreboard bench for instr_fetch_unit with a latency-configurable imem model
module tb_instr_fetch_unit;
  logic CLK = 1'b0, Reset = 1'b1;
  logic branch = 1'b0, uncond_branch = 1'b0, zero = 1'b0;
  logic [63:0] br_pc = '0, br_offset = '0;
`ifdef IFU_PERF_CNT_EN
  logic [31:0] perf_fetched, perf_squashed;
`endif
  ifu_if #(.PC_W(64)) ifc ();
  instr_fetch_unit #(.PC_W(64), .RESET_PC(64'h0)) dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .bus           (ifc.master),
    .branch        (branch),
    .uncond_branch (uncond_branch),
    .zero          (zero),
    .br_pc         (br_pc),
    .br_offset     (br_offset)
`ifdef IFU_PERF_CNT_EN
    ,
    .perf_fetched  (perf_fetched),
    .perf_squashed (perf_squashed)
`endif
  );
  always #5 CLK = ~CLK;
  int vectors = 0, miscompares = 0, hs = 0, lat = 1, cyc, n;
  logic [63:0] exp_addr[$], exp_pc[$];
  logic [31:0] w0;
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    return 32'h8B020020 ^ (a[31:0] << 19);
  endfunction
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask
  task automatic step();
    @(posedge CLK);
    #1;
  endtask
  task automatic wait_valid(input string tag);
    int k = 0;
    while (!ifc.instr_valid && k < 20) begin
      step();
      k++;
    end
    check(tag, 64'(ifc.instr_valid), 1);
  endtask
  // imem: answers each request lat cycles later; shares Reset with the DUT
  initial begin
    int cnt = 0;
    logic [63:0] pend = '0;
    ifc.imem_valid = 1'b0;
    ifc.imem_rdata = '0;
    forever begin
      step();
      ifc.imem_valid = 1'b0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) begin
          ifc.imem_valid = 1'b1;
          ifc.imem_rdata = mem_word(pend);
        end
      end
      if (ifc.imem_req) begin
        pend = ifc.imem_addr;
        cnt  = lat;
      end
      if (Reset) begin
        cnt = 0;
        ifc.imem_valid = 1'b0;
      end
    end
  end
  initial begin
    logic [63:0] p;
    logic [31:0] w;
    forever begin
      @(negedge CLK);
      if (!Reset) begin
        if (ifc.imem_req) begin
          check("req_expected", 64'(exp_addr.size() != 0), 1);
          if (exp_addr.size() != 0) check("req_addr", ifc.imem_addr, exp_addr.pop_front());
        end
        if (ifc.instr_valid && ifc.instr_ready) begin
          hs++;
          check("hs_expected", 64'(exp_pc.size() != 0), 1);
          if (exp_pc.size() != 0) begin
            p = exp_pc.pop_front();
            w = mem_word(p);
            check("hs_pc", ifc.instr_pc, p);
            check("hs_instr", 64'(ifc.instr), 64'(w));
            check("hs_opcode", 64'(ifc.opcode), 64'(w[31:21]));
          end
        end
      end
    end
  end
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end
  initial begin
    ifc.instr_ready = 1'b0;
    w0 = mem_word(64'h0);
    repeat (2) step();
    Reset = 1'b0;
    exp_addr.push_back(64'h0);
    @(negedge CLK);
    check("rst_req", 64'(ifc.imem_req), 0);
    check("rst_valid", 64'(ifc.instr_valid), 0);
    check("rst_instr", 64'(ifc.instr), 0);
    check("rst_pc", ifc.instr_pc, 0);
    check("rst_opcode", 64'(ifc.opcode), 0);
    cyc = 1;
    n = 0;
    while (!ifc.imem_req && n < 20) begin @(negedge CLK); n++; end
    cyc += n;
    check("t1_req_cycle", 64'(cyc), 2);
    n = 0;
    while (!ifc.instr_valid && n < 20) begin @(negedge CLK); n++; end
    cyc += n;
    check("t1_valid_cycle", 64'(cyc), 4);
    check("t1_opcode", 64'(ifc.opcode), 64'(w0[31:21]));
    for (int i = 0; i < 5; i++) begin
      step();
      @(negedge CLK);
      check("t2_valid", 64'(ifc.instr_valid), 1);
      check("t2_instr", 64'(ifc.instr), 64'h8B020020);
      check("t2_pc", ifc.instr_pc, 0);
      check("t2_no_req", 64'(ifc.imem_req), 0);
    end
    step();
    for (int i = 0; i < 4; i++) begin
      exp_pc.push_back(64'(4 * i));
      exp_addr.push_back(64'(4 * i + 4));
    end
    ifc.instr_ready = 1'b1;
    n = 0;
    while (hs < 4 && n < 40) begin step(); n++; end
    ifc.instr_ready = 1'b0;
    check("t3_handshakes", 64'(hs), 4);
    check("t3_all_seen", 64'(exp_pc.size()), 0);
`ifdef IFU_PERF_CNT_EN
    check("t3_perf_fetched", 64'(perf_fetched), 4);
    check("t3_perf_squashed", 64'(perf_squashed), 0);
`endif
    wait_valid("t4_hold_reached");
    uncond_branch = 1'b1;
    br_pc = 64'h8;
    br_offset = 64'd3;
    lat = 2;
    exp_addr.push_back(64'h14);
    @(negedge CLK);
    check("t4_valid_killed", 64'(ifc.instr_valid), 0);
    step();
    uncond_branch = 1'b0;
    @(negedge CLK);
    check("t4_req", 64'(ifc.imem_req), 1);
    check("t4_addr", ifc.imem_addr, 64'h14);
`ifdef IFU_PERF_CNT_EN
    check("t4_perf_squashed", 64'(perf_squashed), 1);
`endif
    step();
    branch = 1'b1;
    zero = 1'b1;
    br_pc = 64'h10;
    br_offset = -64'sd4;
    lat = 1;
    exp_addr.push_back(64'h0);
    @(negedge CLK);
    check("t5_valid_wait", 64'(ifc.instr_valid), 0);
    step();
    branch = 1'b0;
    zero = 1'b0;
    @(negedge CLK);
    check("t5_valid_drop", 64'(ifc.instr_valid), 0);
    check("t5_no_req", 64'(ifc.imem_req), 0);
    step();
    @(negedge CLK);
    check("t5_req", 64'(ifc.imem_req), 1);
    check("t5_addr", ifc.imem_addr, 64'h0);
`ifdef IFU_PERF_CNT_EN
    check("t5_perf_squashed", 64'(perf_squashed), 2);
`endif
    wait_valid("t6_hold_reached");
    branch = 1'b1;
    zero = 1'b0;
    br_pc = 64'h40;
    br_offset = 64'd5;
    ifc.instr_ready = 1'b1;
    exp_pc.push_back(64'h0);
    exp_addr.push_back(64'h4);
    @(negedge CLK);
    check("t6_valid", 64'(ifc.instr_valid), 1);
    step();
    branch = 1'b0;
    ifc.instr_ready = 1'b0;
    @(negedge CLK);
    check("t6_addr", ifc.imem_addr, 64'h4);
    wait_valid("t6_next_valid");
    check("t6_pc", ifc.instr_pc, 64'h4);
    ifc.instr_ready = 1'b1;
    exp_pc.push_back(64'h4);
    exp_addr.push_back(64'h8);
    step();
    ifc.instr_ready = 1'b0;
    step();
    Reset = 1'b1;
    step();
    @(negedge CLK);
    check("t7_valid", 64'(ifc.instr_valid), 0);
    check("t7_req", 64'(ifc.imem_req), 0);
    check("t7_instr", 64'(ifc.instr), 0);
    check("t7_pc", ifc.instr_pc, 0);
    check("t7_opcode", 64'(ifc.opcode), 0);
`ifdef IFU_PERF_CNT_EN
    check("t7_perf_fetched", 64'(perf_fetched), 0);
    check("t7_perf_squashed", 64'(perf_squashed), 0);
`endif
    step();
    Reset = 1'b0;
    exp_addr.push_back(64'h0);
    wait_valid("t7_refetch");
    check("t7_refetch_pc", ifc.instr_pc, 64'h0);
    check("t7_refetch_instr", 64'(ifc.instr), 64'(w0));
    check("end_addr_drained", 64'(exp_addr.size()), 0);
    check("end_pc_drained", 64'(exp_pc.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
